// File: rtl/gs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gs_pkg
// Description : Shared definitions for the grayscale (GS) serial link.
//               Holds the LAT pulse-width command encodings, the GS word
//               width, the bit/LAT counter widths and the receiver state
//               enum.
// Revision    : 1.0 - initial release
// ============================================================================
package gs_pkg;

    // Bits per GS word: 3 colours x 16 bits, sent MSB first.
    localparam int GS_WORD_WIDTH = 48;

    // Counter widths. The bit counter saturates at 2^7-1 and the LAT-width
    // counter saturates at 15.
    localparam int BIT_CNT_WIDTH = 7;
    localparam int LAT_CNT_WIDTH = 4;

    // Commands are encoded by how many SCLK rising edges see LAT high.
    localparam logic [LAT_CNT_WIDTH-1:0] CMD_WRTGS     = 4'd1;
    localparam logic [LAT_CNT_WIDTH-1:0] CMD_LATGS     = 4'd3;
    localparam logic [LAT_CNT_WIDTH-1:0] CMD_LINERESET = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } gs_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sig_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sig_sync_edge
// Description : STAGES-deep flop synchronizer for an asynchronous level,
//               followed by one extra delay flop for rise/fall detection.
//   clk     : system clock
//   rst     : synchronous active-low reset
//   i_din   : asynchronous input level
//   o_sync  : synchronized level
//   o_rise  : one-cycle pulse on a synchronized 0->1 transition
//   o_fall  : one-cycle pulse on a synchronized 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
module sig_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_dly;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_din};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_dly;
    assign o_fall = r_dly & ~o_sync;

endmodule
`default_nettype wire

// File: rtl/gs_driver_receiver.sv
`default_nettype none
// ============================================================================
// Module      : gs_driver_receiver
// Description : LED-driver side of the SIN/SCLK/LAT grayscale link.
//               Deserializes GS words, decodes the LAT pulse width into a
//               command and presents each word with its LED index.
//   clk         : system clock (only clock in the block)
//   rst         : synchronous active-low reset
//   SCLK        : serial clock, sampled as data
//   SIN         : serial data, valid on SCLK rising edge
//   LAT         : latch / command line, changes on SCLK falling edge
//   wr_en       : one-cycle write strobe
//   word_idx    : LED index of the written word (held until next write)
//   word_data   : received word (held until next write)
//   frame_done  : one-cycle pulse on LATGS
//   short_frame : LATGS arrived before the last LED index (held)
//   len_error   : one-cycle pulse, written word had a bad bit count
//   cmd_error   : one-cycle pulse, LAT width is not a known command
// Revision    : 1.0 - initial release
// ============================================================================
module gs_driver_receiver
    import gs_pkg::*;
#(
    parameter  int NB_LEDS_PER_GROUP = 16,
    parameter  int WORD_WIDTH        = GS_WORD_WIDTH,
    parameter  int SYNC_STAGES       = 2,
    localparam int LED_WIDTH         = $clog2(NB_LEDS_PER_GROUP)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  SIN,
    input  logic                  LAT,
    output logic                  wr_en,
    output logic [LED_WIDTH-1:0]  word_idx,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  frame_done,
    output logic                  short_frame,
    output logic                  len_error,
    output logic                  cmd_error
);

    localparam logic [BIT_CNT_WIDTH-1:0] c_bit_max  = '1;
    localparam logic [LAT_CNT_WIDTH-1:0] c_lat_max  = '1;
    localparam logic [BIT_CNT_WIDTH-1:0] c_word_len = BIT_CNT_WIDTH'(WORD_WIDTH);
    localparam logic [LED_WIDTH-1:0]     c_last_idx = LED_WIDTH'(NB_LEDS_PER_GROUP - 1);

    // ------------------------------------------------------------------
    // Input synchronizers. All three lines use the same depth so SIN and
    // LAT stay aligned with the detected SCLK edge.
    // ------------------------------------------------------------------
    logic       w_sclk_rise;
    logic       w_lat_sync;
    logic       w_lat_fall;
    logic       w_sin_sync;
    logic       w_sclk_sync_unused;
    logic       w_sclk_fall_unused;
    logic       w_lat_rise_unused;
    logic [1:0] w_sin_edge_unused;

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_din  (SCLK),
        .o_sync (w_sclk_sync_unused),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall_unused)
    );

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lat (
        .clk    (clk),
        .rst    (rst),
        .i_din  (LAT),
        .o_sync (w_lat_sync),
        .o_rise (w_lat_rise_unused),
        .o_fall (w_lat_fall)
    );

    sig_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sin (
        .clk    (clk),
        .rst    (rst),
        .i_din  (SIN),
        .o_sync (w_sin_sync),
        .o_rise (w_sin_edge_unused[0]),
        .o_fall (w_sin_edge_unused[1])
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    gs_rx_state_t r_state;
    gs_rx_state_t w_next_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            // A LAT pulse with no preceding SCLK edge still has to be
            // decoded so it can be flagged as an empty command.
            ST_IDLE: begin
                if (w_lat_fall) begin
                    w_next_state = ST_DECODE;
                end else if (w_sclk_rise) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_lat_fall) begin
                    w_next_state = ST_DECODE;
                end
            end
            // An SCLK edge landing in DECODE already belongs to the next
            // word, so go straight back to SHIFT rather than dropping it.
            ST_DECODE: begin
                if (w_sclk_rise) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register and counters. In DECODE the counters restart from
    // zero (and the shift register too on LINERESET) while a coincident
    // SCLK edge is still applied on top of the cleared value.
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0]    r_shreg;
    logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
    logic [LAT_CNT_WIDTH-1:0] r_lat_cnt;
    logic [LED_WIDTH-1:0]     r_index;

    logic                     w_in_decode;
    logic                     w_is_linereset;
    logic [WORD_WIDTH-1:0]    w_shreg_base;
    logic [BIT_CNT_WIDTH-1:0] w_bit_base;
    logic [LAT_CNT_WIDTH-1:0] w_lat_base;

    assign w_in_decode    = (r_state == ST_DECODE);
    assign w_is_linereset = w_in_decode && (r_lat_cnt == CMD_LINERESET);
    assign w_shreg_base   = w_is_linereset ? '0 : r_shreg;
    assign w_bit_base     = w_in_decode ? '0 : r_bit_cnt;
    assign w_lat_base     = w_in_decode ? '0 : r_lat_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
        end else begin
            if (w_sclk_rise) begin
                r_shreg   <= {w_shreg_base[WORD_WIDTH-2:0], w_sin_sync};
                r_bit_cnt <= (w_bit_base == c_bit_max) ? c_bit_max
                                                       : w_bit_base + 1'b1;
            end else begin
                r_shreg   <= w_shreg_base;
                r_bit_cnt <= w_bit_base;
            end
            // w_lat_sync is already low on a falling-edge cycle, so the
            // edge that coincides with LAT falling is never counted.
            if (w_sclk_rise && w_lat_sync) begin
                r_lat_cnt <= (w_lat_base == c_lat_max) ? c_lat_max
                                                       : w_lat_base + 1'b1;
            end else begin
                r_lat_cnt <= w_lat_base;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command decode and registered outputs
    // ------------------------------------------------------------------
    logic                  r_wr_en;
    logic [LED_WIDTH-1:0]  r_word_idx;
    logic [WORD_WIDTH-1:0] r_word_data;
    logic                  r_frame_done;
    logic                  r_short_frame;
    logic                  r_len_error;
    logic                  r_cmd_error;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_index       <= '0;
            r_wr_en       <= 1'b0;
            r_word_idx    <= '0;
            r_word_data   <= '0;
            r_frame_done  <= 1'b0;
            r_short_frame <= 1'b0;
            r_len_error   <= 1'b0;
            r_cmd_error   <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_len_error  <= 1'b0;
            r_cmd_error  <= 1'b0;
            if (w_in_decode) begin
                case (r_lat_cnt)
                    CMD_WRTGS: begin
                        r_wr_en     <= 1'b1;
                        r_word_idx  <= r_index;
                        r_word_data <= r_shreg;
                        r_len_error <= (r_bit_cnt != c_word_len);
                        // Power-of-two group size: natural wrap to 0.
                        r_index     <= r_index + 1'b1;
                    end
                    CMD_LATGS: begin
                        r_wr_en       <= 1'b1;
                        r_word_idx    <= r_index;
                        r_word_data   <= r_shreg;
                        r_len_error   <= (r_bit_cnt != c_word_len);
                        r_frame_done  <= 1'b1;
                        r_short_frame <= (r_index != c_last_idx);
                        r_index       <= '0;
                    end
                    CMD_LINERESET: begin
                        r_index <= '0;
                    end
                    default: begin
                        r_cmd_error <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign word_idx    = r_word_idx;
    assign word_data   = r_word_data;
    assign frame_done  = r_frame_done;
    assign short_frame = r_short_frame;
    assign len_error   = r_len_error;
    assign cmd_error   = r_cmd_error;

endmodule
`default_nettype wire

// File: tb/tb_gs_driver_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_gs_driver_receiver
// Description : Directed self-checking bench for gs_driver_receiver.
//               Drives the SIN/SCLK/LAT link bit by bit and records every
//               write strobe into a queue that each scenario task inspects.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gs_driver_receiver;

    logic        clk;
    logic        rst;
    logic        SCLK;
    logic        SIN;
    logic        LAT;
    logic        wr_en;
    logic [3:0]  word_idx;
    logic [47:0] word_data;
    logic        frame_done;
    logic        short_frame;
    logic        len_error;
    logic        cmd_error;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cmd_cnt   = 0;

    typedef struct {
        logic [3:0]  idx;
        logic [47:0] data;
        logic        fd;
        logic        sf;
        logic        le;
    } rec_t;

    rec_t wr_q[$];

    gs_driver_receiver #(
        .NB_LEDS_PER_GROUP (16),
        .WORD_WIDTH        (48),
        .SYNC_STAGES       (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .SCLK        (SCLK),
        .SIN         (SIN),
        .LAT         (LAT),
        .wr_en       (wr_en),
        .word_idx    (word_idx),
        .word_data   (word_data),
        .frame_done  (frame_done),
        .short_frame (short_frame),
        .len_error   (len_error),
        .cmd_error   (cmd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs change on posedge; record them half a period later.
    always @(negedge clk) begin
        rec_t r;
        if (wr_en === 1'b1) begin
            r.idx  = word_idx;
            r.data = word_data;
            r.fd   = frame_done;
            r.sf   = short_frame;
            r.le   = len_error;
            wr_q.push_back(r);
        end
        if (cmd_error === 1'b1) cmd_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift the low nbits of data MSB first; LAT is high for the last latn
    // SCLK rising edges. SIN/LAT change together with SCLK falling.
    task automatic send_bits(input logic [47:0] data, input int nbits, input int latn);
        for (int i = nbits - 1; i >= 0; i--) begin
            SCLK = 1'b0;
            SIN  = data[i];
            LAT  = (i < latn);
            tick(3);
            SCLK = 1'b1;
            tick(3);
        end
    endtask

    task automatic send_word(input logic [47:0] data, input int nbits, input int latn);
        send_bits(data, nbits, latn);
        SCLK = 1'b0;
        LAT  = 1'b0;
        SIN  = 1'b0;
        tick(20);
    endtask

    task automatic line_reset();
        send_word(48'h0, 7, 7);
    endtask

    task automatic test_reset();
        logic [56:0] outs;
        rst  = 1'b0;
        SCLK = 1'b0;
        SIN  = 1'b0;
        LAT  = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) begin
            SCLK = ~SCLK;
            SIN  = 1'($urandom_range(0, 1));
            tick(1);
            outs = {wr_en, frame_done, short_frame, len_error, cmd_error, word_idx, word_data};
            total_cnt++;
            if (outs !== 57'h0) $display("FAIL reset_outputs cycle %0d: got %h want 0", i, outs);
            else pass_cnt++;
        end
        SCLK = 1'b0;
        SIN  = 1'b0;
        rst  = 1'b1;
        tick(12);
        total_cnt++;
        if (wr_q.size() !== 0) $display("FAIL reset_no_write: got %0d writes want 0", wr_q.size());
        else pass_cnt++;
        total_cnt++;
        if (cmd_cnt !== 0) $display("FAIL reset_no_cmd_error: got %0d want 0", cmd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_single_wrtgs();
        wr_q.delete();
        send_word(48'hA5A5_0F0F_1234, 48, 1);
        total_cnt++;
        if (wr_q.size() !== 1) $display("FAIL single_count: got %0d want 1", wr_q.size());
        else pass_cnt++;
        if (wr_q.size() > 0) begin
            total_cnt++;
            if (wr_q[0].idx !== 4'd0) $display("FAIL single_idx: got %0d want 0", wr_q[0].idx);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].data !== 48'hA5A5_0F0F_1234)
                $display("FAIL single_data: got %h want a5a50f0f1234", wr_q[0].data);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].le !== 1'b0) $display("FAIL single_len_error: got %b want 0", wr_q[0].le);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].fd !== 1'b0) $display("FAIL single_frame_done: got %b want 0", wr_q[0].fd);
            else pass_cnt++;
        end
    endtask

    task automatic test_full_frame();
        line_reset();
        wr_q.delete();
        for (int i = 0; i < 16; i++) begin
            send_word(48'(i), 48, (i == 15) ? 3 : 1);
        end
        total_cnt++;
        if (wr_q.size() !== 16) $display("FAIL frame_count: got %0d want 16", wr_q.size());
        else pass_cnt++;
        for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
            total_cnt++;
            if (wr_q[i].idx !== 4'(i)) $display("FAIL frame_idx[%0d]: got %0d want %0d", i, wr_q[i].idx, i);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[i].data !== 48'(i)) $display("FAIL frame_data[%0d]: got %h want %h", i, wr_q[i].data, 48'(i));
            else pass_cnt++;
            total_cnt++;
            if (wr_q[i].fd !== (i == 15)) $display("FAIL frame_done[%0d]: got %b want %b", i, wr_q[i].fd, (i == 15));
            else pass_cnt++;
        end
        if (wr_q.size() == 16) begin
            total_cnt++;
            if (wr_q[15].sf !== 1'b0) $display("FAIL frame_short_flag: got %b want 0", wr_q[15].sf);
            else pass_cnt++;
        end
        wr_q.delete();
        send_word(48'h0000_1111_2222, 48, 1);
        total_cnt++;
        if (wr_q.size() !== 1 || wr_q[0].idx !== 4'd0)
            $display("FAIL frame_next_idx: got size %0d idx %0d want size 1 idx 0",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].idx : 4'hx);
        else pass_cnt++;
    endtask

    task automatic test_short_frame();
        line_reset();
        wr_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_word(48'h00AB_0000_0000 + 48'(i), 48, (i == 4) ? 3 : 1);
        end
        total_cnt++;
        if (wr_q.size() !== 5) $display("FAIL short_count: got %0d want 5", wr_q.size());
        else pass_cnt++;
        if (wr_q.size() == 5) begin
            total_cnt++;
            if (wr_q[4].idx !== 4'd4) $display("FAIL short_idx: got %0d want 4", wr_q[4].idx);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[4].fd !== 1'b1) $display("FAIL short_frame_done: got %b want 1", wr_q[4].fd);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[4].sf !== 1'b1) $display("FAIL short_flag: got %b want 1", wr_q[4].sf);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[4].data !== 48'h00AB_0000_0004) $display("FAIL short_data: got %h want 00ab00000004", wr_q[4].data);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[3].fd !== 1'b0) $display("FAIL short_early_done: got %b want 0", wr_q[3].fd);
            else pass_cnt++;
        end
    endtask

    task automatic test_errors();
        // LINERESET: no write, index and shift register cleared.
        wr_q.delete();
        cmd_cnt = 0;
        line_reset();
        total_cnt++;
        if (wr_q.size() !== 0) $display("FAIL lreset_no_write: got %0d want 0", wr_q.size());
        else pass_cnt++;
        total_cnt++;
        if (cmd_cnt !== 0) $display("FAIL lreset_cmd_error: got %0d want 0", cmd_cnt);
        else pass_cnt++;

        // 40-bit word: upper 8 bits come from the cleared shift register.
        send_word(48'h0000_1234_5678_9A, 40, 1);
        total_cnt++;
        if (wr_q.size() !== 1) $display("FAIL short_word_count: got %0d want 1", wr_q.size());
        else pass_cnt++;
        if (wr_q.size() == 1) begin
            total_cnt++;
            if (wr_q[0].le !== 1'b1) $display("FAIL short_word_len_error: got %b want 1", wr_q[0].le);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].data !== 48'h0012_3456_789A) $display("FAIL short_word_data: got %h want 00123456789a", wr_q[0].data);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].idx !== 4'd0) $display("FAIL short_word_idx: got %0d want 0", wr_q[0].idx);
            else pass_cnt++;
        end

        // Unknown width 5: flagged, no write, index stays at 1.
        wr_q.delete();
        send_word(48'h0000_0000_DEAD, 48, 5);
        total_cnt++;
        if (cmd_cnt !== 1) $display("FAIL cmd5_error: got %0d pulses want 1", cmd_cnt);
        else pass_cnt++;
        total_cnt++;
        if (wr_q.size() !== 0) $display("FAIL cmd5_no_write: got %0d want 0", wr_q.size());
        else pass_cnt++;
        send_word(48'hBEEF_0000_CAFE, 48, 1);
        total_cnt++;
        if (wr_q.size() !== 1 || wr_q[0].idx !== 4'd1 || wr_q[0].le !== 1'b0)
            $display("FAIL cmd5_index_kept: got size %0d idx %0d want size 1 idx 1 len_error 0",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].idx : 4'hx);
        else pass_cnt++;

        // LINERESET with a full word: no write, next write returns to idx 0.
        wr_q.delete();
        send_word(48'h1234_5678_9ABC, 48, 7);
        total_cnt++;
        if (wr_q.size() !== 0) $display("FAIL lat7_no_write: got %0d want 0", wr_q.size());
        else pass_cnt++;
        send_word(48'h5555_AAAA_5555, 48, 1);
        total_cnt++;
        if (wr_q.size() !== 1 || wr_q[0].idx !== 4'd0)
            $display("FAIL lat7_index_zero: got size %0d idx %0d want size 1 idx 0",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0].idx : 4'hx);
        else pass_cnt++;
        total_cnt++;
        if (cmd_cnt !== 1) $display("FAIL errors_cmd_total: got %0d want 1", cmd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_word();
        wr_q.delete();
        send_bits(48'hFFFF_FFFF_FFFF, 20, 0);
        SCLK = 1'b0;
        rst  = 1'b0;
        tick(3);
        total_cnt++;
        if ({word_idx, word_data} !== 52'h0) $display("FAIL midrst_cleared: got %h want 0", {word_idx, word_data});
        else pass_cnt++;
        rst = 1'b1;
        tick(5);
        send_word(48'h0123_4567_89AB, 48, 1);
        total_cnt++;
        if (wr_q.size() !== 1) $display("FAIL midrst_count: got %0d want 1", wr_q.size());
        else pass_cnt++;
        if (wr_q.size() == 1) begin
            total_cnt++;
            if (wr_q[0].idx !== 4'd0) $display("FAIL midrst_idx: got %0d want 0", wr_q[0].idx);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].data !== 48'h0123_4567_89AB) $display("FAIL midrst_data: got %h want 0123456789ab", wr_q[0].data);
            else pass_cnt++;
            total_cnt++;
            if (wr_q[0].le !== 1'b0) $display("FAIL midrst_len_error: got %b want 0", wr_q[0].le);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single_wrtgs();
        test_full_frame();
        test_short_frame();
        test_errors();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
